axis_stream_buffer: RTL

- Parametrised single-clock AXI-Stream buffer; successor to the write-counter/read-counter stream memory.
- Adds real backpressure on both sides, stored tlast/tstrb per beat, full/empty occupancy and an optional store-and-forward packet mode.
- Sits between an AXIS producer and consumer stage in the lab datapath.

---
 rtl/axis_buf_pkg.sv | 20 ++
 rtl/axis_stream_buffer_if.sv | 13 +
 rtl/axis_buf_ram.sv | 29 ++
 rtl/axis_stream_buffer.sv | 95 +++++++++
 4 files changed

// File: rtl/axis_buf_pkg.sv
// Shared sizing helpers for the AXI-Stream buffer: depth, counter and RAM entry widths.
package axis_buf_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic int depth_of(input int addr_width);
      return 1 << addr_width;
   endfunction

   // One RAM entry holds {tlast, tstrb, tdata}.
   function automatic int entry_w(input int data_width);
      return data_width + data_width / 8 + 1;
   endfunction

endpackage

// File: rtl/axis_stream_buffer_if.sv
// AXI-Stream handshake bundle; master drives payload/valid, slave drives ready.
interface axis_stream_buffer_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic                    tvalid;
   logic                    tlast;
   logic                    tready;

   modport master (output tdata, tstrb, tvalid, tlast, input tready);
   modport slave  (input tdata, tstrb, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_buf_ram.sv
// Simple dual-port RAM; the read register doubles as the stream output register.
module axis_buf_ram
   import axis_buf_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int WIDTH      = 37
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]      rdata
);
   localparam int DEPTH = depth_of(ADDR_WIDTH);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/axis_stream_buffer.sv
// Single-clock AXI-Stream buffer with full backpressure and optional store-and-forward
// packet release; pointers, counters and release logic live here, storage in axis_buf_ram.
module axis_stream_buffer
   import axis_buf_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 4,
   parameter int PACKET_MODE = 0
) (
   input  logic                  axis_aclk,
   input  logic                  axis_areset,
   axis_stream_buffer_if.slave   s_axis,
   axis_stream_buffer_if.master  m_axis,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  oversize
);
   localparam int DEPTH   = depth_of(ADDR_WIDTH);
   localparam int STRB_W  = DATA_WIDTH / 8;
   localparam int ENTRY_W = entry_w(DATA_WIDTH);
   localparam int CNT_W   = clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic [CNT_W-1:0]   wr_ptr, rd_ptr, ram_cnt, pkt_cnt;
   logic [DEPTH-1:0]   last_map;
   logic [ENTRY_W-1:0] wr_entry, rd_entry;
   logic               wr_en, load, avail, head_last, out_vld, force_release, stuck;

   // Pointers carry one extra bit so full and empty are distinguishable.
   assign ram_cnt        = wr_ptr - rd_ptr;
   assign s_axis.tready  = !axis_areset && (ram_cnt != DEPTH_C);
   assign wr_en          = s_axis.tvalid && s_axis.tready;
   assign head_last      = last_map[rd_ptr[ADDR_WIDTH-1:0]];
   assign avail          = (ram_cnt != '0) &&
                           ((PACKET_MODE == 0) || (pkt_cnt != '0) || force_release);
   assign load           = avail && (!out_vld || m_axis.tready);
   // A full RAM with no complete packet inside can never release on its own.
   assign stuck          = (PACKET_MODE != 0) && (ram_cnt == DEPTH_C) && (pkt_cnt == '0);
   assign wr_entry       = {s_axis.tlast, s_axis.tstrb, s_axis.tdata};

   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         pkt_cnt       <= '0;
         out_vld       <= 1'b0;
         force_release <= 1'b0;
         oversize      <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + ONE_C;
         if (load)  rd_ptr <= rd_ptr + ONE_C;

         case ({wr_en && s_axis.tlast, load && head_last})
            2'b10:   pkt_cnt <= pkt_cnt + ONE_C;
            2'b01:   pkt_cnt <= pkt_cnt - ONE_C;
            default: pkt_cnt <= pkt_cnt;
         endcase

         if (load)                out_vld <= 1'b1;
         else if (m_axis.tready)  out_vld <= 1'b0;

         if (stuck) begin
            force_release <= 1'b1;
            oversize      <= 1'b1;
         end else if (load && head_last) begin
            force_release <= 1'b0;
         end
      end
   end

   // tlast shadow so the release logic knows the head beat's tlast before it is read out.
   always_ff @(posedge axis_aclk) begin
      if (wr_en) last_map[wr_ptr[ADDR_WIDTH-1:0]] <= s_axis.tlast;
   end

   axis_buf_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WIDTH      (ENTRY_W)
   ) u_ram (
      .clk   (axis_aclk),
      .rst   (axis_areset),
      .we    (wr_en),
      .waddr (wr_ptr[ADDR_WIDTH-1:0]),
      .wdata (wr_entry),
      .re    (load),
      .raddr (rd_ptr[ADDR_WIDTH-1:0]),
      .rdata (rd_entry)
   );

   assign m_axis.tdata  = rd_entry[DATA_WIDTH-1:0];
   assign m_axis.tstrb  = rd_entry[DATA_WIDTH +: STRB_W];
   assign m_axis.tlast  = rd_entry[ENTRY_W-1];
   assign m_axis.tvalid = out_vld;
   assign level         = ram_cnt + CNT_W'(out_vld);
endmodule
